// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns an EX/MEM access into one req/gnt data-bus
// transaction, formats store lanes and load results, and stalls the pipeline meanwhile.
module mem_access_unit #(
  parameter int DATA_WIDTH          = 32,
  parameter int DATA_ADDR_WIDTH     = 32,
  parameter int REGISTER_ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_ADDR_WIDTH-1:0] alu_res_EX_MEM_o,
  input  logic [DATA_WIDTH-1:0]      write_data_EX_MEM_o,
  input  logic                       mem_write_EX_MEM_o,
  input  logic [1:0]                 result_sel_EX_MEM_o,
  input  logic [2:0]                 funct3_EX_MEM_o,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DATA_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]      dmem_wdata,
  output logic [3:0]                 dmem_wstrb,
  input  logic                       dmem_gnt,
  input  logic                       dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]      dmem_rdata,
  output logic [DATA_WIDTH-1:0]      load_data_MEM,
  output logic                       load_valid_MEM,
  output logic                       stall_MEM,
  output logic                       misaligned_MEM
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic                       req_q, req_d;
  logic                       we_q, we_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [3:0]                 wstrb_q, wstrb_d;
  logic [1:0]                 off_q, off_d;
  logic [1:0]                 size_q, size_d;
  logic                       uns_q, uns_d;
  logic [DATA_WIDTH-1:0]      load_data_q, load_data_d;
  logic                       load_valid_q, load_valid_d;
  logic                       misaligned_q, misaligned_d;

  logic       is_store, is_load, is_access;
  logic       f3_legal, addr_misaligned, access_ok, access_bad;
  logic [1:0] off;

  // Access classification; a store wins when both store and load are flagged.
  always_comb begin
    off             = alu_res_EX_MEM_o[1:0];
    is_store        = mem_write_EX_MEM_o;
    is_load         = !mem_write_EX_MEM_o && (result_sel_EX_MEM_o == 2'b01);
    is_access       = is_store || is_load;
    if (is_store) begin
      f3_legal = funct3_EX_MEM_o inside {3'b000, 3'b001, 3'b010};
    end else begin
      f3_legal = funct3_EX_MEM_o inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    addr_misaligned = ((funct3_EX_MEM_o[1:0] == 2'b01) && off[0]) ||
                      ((funct3_EX_MEM_o[1:0] == 2'b10) && (off != 2'b00));
    access_ok       = is_access && f3_legal && !addr_misaligned;
    access_bad      = is_access && !(f3_legal && !addr_misaligned);
  end

  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_wstrb;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_wdata[gi*8 +: 8] =
      (funct3_EX_MEM_o[1:0] == 2'b00) ? write_data_EX_MEM_o[7:0] :
      (funct3_EX_MEM_o[1:0] == 2'b01) ? write_data_EX_MEM_o[(gi%2)*8 +: 8] :
                                        write_data_EX_MEM_o[gi*8 +: 8];
  end

  always_comb begin
    case (funct3_EX_MEM_o[1:0])
      2'b00:   st_wstrb = 4'b0001 << off;
      2'b01:   st_wstrb = 4'b0011 << off;
      default: st_wstrb = 4'b1111;
    endcase
  end

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_fmt;

  // Load formatting uses the captured offset/size, not the live EX/MEM inputs.
  always_comb begin
    ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b00:   ld_fmt = {{24{!uns_q && ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{!uns_q && ld_half[15]}}, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access_ok) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {alu_res_EX_MEM_o[DATA_ADDR_WIDTH-1:2], 2'b00};
          wdata_d = is_store ? st_wdata : '0;
          wstrb_d = is_store ? st_wstrb : 4'b0000;
          off_d   = off;
          size_d  = funct3_EX_MEM_o[1:0];
          uns_d   = funct3_EX_MEM_o[2];
        end else if (access_bad) begin
          misaligned_d = 1'b1;
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          load_data_d  = ld_fmt;
          load_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= 4'b0000;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Stall rises in the same cycle an access is accepted so EX/MEM freezes on it.
  assign stall_MEM      = ((state_q == S_IDLE) && access_ok) ||
                          (state_q == S_REQ) || (state_q == S_WAIT);
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_wstrb     = wstrb_q;
  assign load_data_MEM  = load_data_q;
  assign load_valid_MEM = load_valid_q;
  assign misaligned_MEM = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// checked against a transaction-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_res_EX_MEM_o;
  logic [31:0] write_data_EX_MEM_o;
  logic        mem_write_EX_MEM_o;
  logic [1:0]  result_sel_EX_MEM_o;
  logic [2:0]  funct3_EX_MEM_o;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data_MEM;
  logic        load_valid_MEM, stall_MEM, misaligned_MEM;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_load = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .alu_res_EX_MEM_o    (alu_res_EX_MEM_o),
    .write_data_EX_MEM_o (write_data_EX_MEM_o),
    .mem_write_EX_MEM_o  (mem_write_EX_MEM_o),
    .result_sel_EX_MEM_o (result_sel_EX_MEM_o),
    .funct3_EX_MEM_o     (funct3_EX_MEM_o),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_wstrb          (dmem_wstrb),
    .dmem_gnt            (dmem_gnt),
    .dmem_rvalid         (dmem_rvalid),
    .dmem_rdata          (dmem_rdata),
    .load_data_MEM       (load_data_MEM),
    .load_valid_MEM      (load_valid_MEM),
    .stall_MEM           (stall_MEM),
    .misaligned_MEM      (misaligned_MEM)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: access sizes in bytes, lanes by byte arithmetic.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit lg;
    if (st) lg = (f3 <= 3'd2);
    else    lg = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return lg && ((a % m_size(f3)) == 0);
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int n = m_size(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (m_size(f3))
      1:       return (wd & 32'hFF) * 32'h01010101;
      2:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v = rd >> ((a % 4) * 8);
    int          b = int'(v & 32'hFF);
    int          h = int'(v & 32'hFFFF);
    case (f3)
      3'd0:    return 32'((b >= 128) ? b - 256 : b);
      3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return rd;
    endcase
  endfunction

  task automatic clear_inputs();
    mem_write_EX_MEM_o  = 1'b0;
    result_sel_EX_MEM_o = 2'b00;
    funct3_EX_MEM_o     = 3'($urandom);
    alu_res_EX_MEM_o    = $urandom;
    write_data_EX_MEM_o = $urandom;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    last_load = 32'h0;
  endtask

  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gnt_dly, input int rv_dly);
    bit ok       = m_legal(st, f3, a);
    int stalls   = 1;
    int gcnt     = gnt_dly;
    int rcnt     = rv_dly;
    bit granted  = 1'b0;
    bit finished = 1'b0;
    @(negedge clk);
    check_eq("idle_req", dmem_req, 0);
    check_eq("idle_lvalid", load_valid_MEM, 0);
    check_eq("idle_mis", misaligned_MEM, 0);
    check_eq("ld_hold", load_data_MEM, last_load);
    mem_write_EX_MEM_o  = st;
    result_sel_EX_MEM_o = st ? 2'($urandom) : 2'b01;
    funct3_EX_MEM_o     = f3;
    alu_res_EX_MEM_o    = a;
    write_data_EX_MEM_o = wd;
    #1;
    check_eq("stall_idle", stall_MEM, ok);
    $display("access st=%0d f3=%0d addr=%08h wd=%08h rd=%08h gnt_dly=%0d rv_dly=%0d legal=%0d",
             st, f3, a, wd, rd, gnt_dly, rv_dly, ok);
    if (!ok) begin
      @(negedge clk);
      check_eq("mis_pulse", misaligned_MEM, 1);
      check_eq("mis_req", dmem_req, 0);
      check_eq("mis_stall", stall_MEM, 0);
      clear_inputs();
      return;
    end
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (!stall_MEM) begin
        finished = 1'b1;
        check_eq("stall_cycles", stalls, st ? 2 + gnt_dly : 3 + gnt_dly + rv_dly);
        check_eq("done_req", dmem_req, 0);
        check_eq("done_lvalid", load_valid_MEM, !st);
        if (!st) begin
          last_load = m_load(f3, a, rd);
          check_eq("load_data", load_data_MEM, last_load);
        end
        clear_inputs();
      end else begin
        stalls++;
        if (!granted) begin
          check_eq("req", dmem_req, 1);
          check_eq("we", dmem_we, st);
          check_eq("addr", dmem_addr, a & ~32'h3);
          if (st) begin
            check_eq("wstrb", dmem_wstrb, m_wstrb(f3, a));
            check_eq("wdata", dmem_wdata, m_wdata(f3, wd));
          end
          dmem_rvalid = 1'($urandom_range(0, 1));
          if (gcnt == 0) begin
            dmem_gnt = 1'b1;
            granted  = 1'b1;
          end else begin
            gcnt--;
          end
        end else begin
          check_eq("wait_req", dmem_req, 0);
          if (rcnt == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rd;
          end else begin
            rcnt--;
          end
        end
      end
    end
    if (!finished) begin
      check_eq("timeout", 0, 1);
      clear_inputs();
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      pulse_reset();
    end
  endtask

  initial begin
    rst         = 1'b1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_we", dmem_we, 0);
    check_eq("rst_addr", dmem_addr, 0);
    check_eq("rst_wdata", dmem_wdata, 0);
    check_eq("rst_wstrb", dmem_wstrb, 0);
    check_eq("rst_ldata", load_data_MEM, 0);
    check_eq("rst_lvalid", load_valid_MEM, 0);
    check_eq("rst_mis", misaligned_MEM, 0);
    check_eq("rst_stall", stall_MEM, 0);
    mem_write_EX_MEM_o = 1'b1;
    funct3_EX_MEM_o    = 3'd2;
    alu_res_EX_MEM_o   = 32'h100;
    #1;
    check_eq("rst_stall_access", stall_MEM, 1);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;

    do_access(1'b1, 3'd0, 32'h1003, 32'h000000A5, 32'h0, 0, 0);
    do_access(1'b0, 3'd0, 32'h2001, 32'h0, 32'h12F08034, 0, 0);
    do_access(1'b0, 3'd4, 32'h2001, 32'h0, 32'h12F08034, 0, 0);
    do_access(1'b0, 3'd1, 32'h2002, 32'h0, 32'h80017FFF, 0, 0);
    do_access(1'b0, 3'd2, 32'h3002, 32'h0, 32'h0, 0, 0);
    do_access(1'b1, 3'd2, 32'h4000, 32'hDEADBEEF, 32'h0, 3, 0);
    do_access(1'b1, 3'd1, 32'h4006, 32'h1234BEEF, 32'h0, 1, 0);
    do_access(1'b1, 3'd4, 32'h4000, 32'h11111111, 32'h0, 0, 0);
    do_access(1'b0, 3'd5, 32'h5002, 32'h0, 32'hFEDC0123, 2, 2);

    // Reset in WAIT abandons the load; a later rvalid must not complete it.
    @(negedge clk);
    mem_write_EX_MEM_o  = 1'b0;
    result_sel_EX_MEM_o = 2'b01;
    funct3_EX_MEM_o     = 3'd2;
    alu_res_EX_MEM_o    = 32'h6000;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_eq("rm_wait_req", dmem_req, 0);
    check_eq("rm_wait_stall", stall_MEM, 1);
    rst = 1'b1;
    #1;
    check_eq("rm_req", dmem_req, 0);
    check_eq("rm_lvalid", load_valid_MEM, 0);
    check_eq("rm_ldata", load_data_MEM, 0);
    check_eq("rm_stall_access", stall_MEM, 1);
    clear_inputs();
    #1;
    check_eq("rm_stall", stall_MEM, 0);
    @(negedge clk);
    rst       = 1'b0;
    last_load = 32'h0;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check_eq("rm_late_lvalid", load_valid_MEM, 0);
    check_eq("rm_late_ldata", load_data_MEM, 0);
    check_eq("rm_late_req", dmem_req, 0);
    check_eq("rm_late_stall", stall_MEM, 0);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      do_access(1'($urandom_range(0, 1)), 3'($urandom), a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    check_eq("final_lvalid", load_valid_MEM, 0);
    check_eq("final_ldata", load_data_MEM, last_load);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
- REQ-001 Parameter DATA_WIDTH, 32: data word width; only 32 is supported.
- REQ-002 Parameter DATA_ADDR_WIDTH, 32: data address width.
- REQ-003 Parameter REGISTER_ADDR_WIDTH, 5: register index width.
- REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
- REQ-005 clk  in  1  clock; all state updates on the rising edge.
- REQ-006 rst  in  1  asynchronous active-high reset.
- REQ-007 alu_res_EX_MEM_o  in  DATA_ADDR_WIDTH  byte address of the access.
- REQ-008 write_data_EX_MEM_o  in  DATA_WIDTH  store data, right-aligned.
- REQ-009 mem_write_EX_MEM_o  in  1  store request.
- REQ-010 result_sel_EX_MEM_o  in  2  value 2'b01 marks a load.
- REQ-011 funct3_EX_MEM_o  in  3  access size and signedness.
- REQ-012 dmem_req  out  1  bus request; held until granted.
- REQ-013 dmem_we  out  1  bus write enable.
- REQ-014 dmem_addr  out  DATA_ADDR_WIDTH  word-aligned address, with [1:0]=0.
- REQ-015 dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
- REQ-016 dmem_wstrb  out  4  byte-lane strobes.
- REQ-017 dmem_gnt  in  1  the bus has accepted the request.
- REQ-018 dmem_rvalid  in  1  read data is valid.
- REQ-019 dmem_rdata  in  DATA_WIDTH  read word.
- REQ-020 load_data_MEM  out  DATA_WIDTH  formatted load result.
- REQ-021 load_valid_MEM  out  1  one-cycle pulse marking load_data_MEM valid.
- REQ-022 stall_MEM  out  1  freezes the IF/ID/EX stages and the EX/MEM register.
- REQ-023 misaligned_MEM  out  1  one-cycle pulse for a misaligned or illegal access.

Function
- REQ-024 A cycle is an access when it is a load or when mem_write_EX_MEM_o=1; if both hold, the store takes precedence.
- REQ-025 The unit is legal when funct3 is 000, 001 or 010 for a store, and 000, 001, 010, 100 or 101 for a load.
- REQ-026 Misaligned access: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
- REQ-027 FSM states are IDLE, REQ, WAIT, DONE.
- REQ-028 IDLE, legal aligned access: capture address, data, strobes, size and signedness into registers; assert stall_MEM combinationally in the same cycle; go to REQ.
- REQ-029 IDLE, misaligned or illegal access: pulse misaligned_MEM for one cycle; issue no bus request; keep stall_MEM=0; stay in IDLE.
- REQ-030 REQ: drive dmem_req=1 and the bus outputs from the captured registers; keep stall_MEM=1.
- REQ-031 REQ, on dmem_gnt=1: a store goes to DONE; a load goes to WAIT.
- REQ-032 While dmem_req=1 and dmem_gnt=0, the bus outputs shall hold stable.
- REQ-033 WAIT: dmem_req=0 and stall_MEM=1; on dmem_rvalid=1, register the formatted load into load_data_MEM and go to DONE.
- REQ-034 dmem_rvalid is ignored in every state except WAIT.
- REQ-035 DONE: stall_MEM=0; for a load, load_valid_MEM=1; ignore the inputs; return to IDLE on the next cycle.
- REQ-036 Minimum latency from access to stall release is 2 cycles for a store (gnt in the first REQ cycle) and 3 cycles for a load (rvalid on the cycle after gnt).
- REQ-037 Store strobes: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111.
- REQ-038 Store data: SB replicates byte [7:0] into all four lanes; SH replicates half [15:0] into both halves; SW passes the word through.
- REQ-039 Load lane select: byte lane addr[1:0]; half lane addr[1].
- REQ-040 Load extension: LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- REQ-041 load_data_MEM holds its value until the next load completes.
- REQ-042 Back-to-back accesses: after DONE, a new access is sampled in IDLE with no extra bubble.

Reset
- REQ-043 While rst=1, the FSM is forced to IDLE asynchronously.
- REQ-044 Reset values: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, load_data_MEM=0, load_valid_MEM=0, misaligned_MEM=0.
- REQ-045 stall_MEM=0 during reset, unless the inputs already present an access (combinational output).
- REQ-046 Reset in REQ or WAIT abandons the transaction; a later dmem_rvalid is ignored.

Verification
- REQ-047 Byte store: SB, addr 0x1003, data 0x000000A5, gnt in the first REQ cycle -> dmem_addr=0x1000, wstrb=4'b1000, wdata=0xA5A5A5A5, dmem_we=1; stall_MEM high for 2 cycles.
- REQ-048 Signed byte load: LB, addr 0x2001, rdata 0x12F0_8034 -> load_data_MEM=0xFFFFFF80 with load_valid_MEM pulse; LBU at the same address -> 0x00000080.
- REQ-049 Half load: LH, addr 0x2002, rdata 0x8001_7FFF -> load_data_MEM=0xFFFF8001.
- REQ-050 Misaligned: LW at addr 0x3002 -> misaligned_MEM pulses; dmem_req stays 0; stall_MEM stays 0.
- REQ-051 Backpressure: SW with gnt held low for 3 cycles -> dmem_req and all bus outputs stable for 4 cycles; DONE follows one cycle after gnt.
- REQ-052 Reset mid-load: rst asserted in WAIT, then rvalid=1 -> FSM in IDLE; load_valid_MEM=0; load_data_MEM=0.
